int_ctrl: RTL

Parametrised nested-interrupt controller for the pipelined CPU. It captures requests from N sources into a pending register and tracks in-service interrupts in an in-service register (IRS). It offers the pipeline the highest-priority pending source that outranks everything in service, moves that source into service on acknowledge, and retires the top in-service level on `eret`. It sits between the external interrupt lines and the pipeline's exception/redirect logic, and supersedes the fixed 3-source combinational next-interrupt selector.

---
 rtl/int_ctrl_pkg.sv | 13 +
 rtl/int_ctrl_prio_enc.sv | 22 ++
 rtl/int_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the nested-interrupt controller: id width helper,
// default vector layout and the priority convention (higher index wins).
package int_ctrl_pkg;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam int          VEC_STRIDE_DEF = 4;

  // Width of a source index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Highest-set-bit encoder: source index N-1 has the highest priority.
module int_ctrl_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = id_w(N)
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Ascending scan; the last (highest) set bit wins.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Nested interrupt controller: pending capture, in-service tracking, offer of
// the highest eligible source above the current service level.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter  int          N          = 3,
  parameter  bit          EDGE       = 1'b1,
  parameter  logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter  int          VEC_STRIDE = VEC_STRIDE_DEF,
  localparam int          ID_W       = id_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    irq_in,
  input  logic [N-1:0]    irq_mask,
  input  logic            ie,
  input  logic            int_ack,
  input  logic            eret,
  output logic            int_req,
  output logic [ID_W-1:0] int_id,
  output logic [31:0]     int_vec,
  output logic [N-1:0]    int_pending,
  output logic [N-1:0]    int_inservice,
  output logic            int_busy
);

  logic [N-1:0]    irq_q, pend, irs;
  logic [N-1:0]    above_top, eligible, set_vec, ack_oh, ret_oh;
  logic            top_valid, elig_valid;
  logic [ID_W-1:0] top_idx, elig_idx;

  int_ctrl_prio_enc #(.N(N)) u_top_enc (
    .vec   (irs),
    .valid (top_valid),
    .idx   (top_idx)
  );

  // Only sources strictly above the current service level may preempt it.
  always_comb begin
    above_top = '0;
    for (int i = 0; i < N; i++) begin
      above_top[i] = !top_valid || (i > int'(top_idx));
    end
  end

  assign eligible = pend & ~irq_mask & above_top;

  int_ctrl_prio_enc #(.N(N)) u_elig_enc (
    .vec   (eligible),
    .valid (elig_valid),
    .idx   (elig_idx)
  );

  assign int_req       = ie && elig_valid;
  assign int_id        = int_req ? elig_idx : '0;
  assign int_vec       = VEC_BASE + (32'(int_id) * 32'(VEC_STRIDE));
  assign int_pending   = pend;
  assign int_inservice = irs;
  assign int_busy      = |irs;

  assign set_vec = EDGE ? (irq_in & ~irq_q) : irq_in;

  always_comb begin
    ack_oh = '0;
    ret_oh = '0;
    if (int_ack && int_req) ack_oh[int_id]  = 1'b1;
    if (eret && top_valid)  ret_oh[top_idx] = 1'b1;
  end

  // A new request arriving on the bit being acknowledged is kept (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= '0;
      pend  <= '0;
      irs   <= '0;
    end else begin
      irq_q <= irq_in;
      pend  <= (pend & ~ack_oh) | set_vec;
      irs   <= (irs & ~ret_oh) | ack_oh;
    end
  end

endmodule
